// File: rtl/pc_sequenciador.sv
// Program-counter sequencer: holds the PC, fetches over a req/ack handshake and
// chooses the next PC among sequential, branch and jump targets, trapping misaligned targets.
module pc_sequenciador #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Addresult,
    input  logic [25:0] jumpIndex,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        stall,
    input  logic        imemAck,
    output logic        imemReq,
    output logic [31:0] pc,
    output logic [31:0] pcincrementado,
    output logic        instrValid,
    output logic        trap,
    output logic [31:0] trapAddr
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StTrap} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] trap_addr_q, trap_addr_d;
    logic [31:0] next_pc;

    assign pcincrementado = pc_q + 32'd4;

    // Jump wins over a taken branch, so a jump never reaches the alignment check on Addresult.
    always_comb begin
        next_pc = pcincrementado;
        if (jump) begin
            next_pc = {pcincrementado[31:28], jumpIndex, 2'b00};
        end else if (branch && zero) begin
            next_pc = Addresult;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        trap_addr_d = trap_addr_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (imemAck) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!stall) begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = StFetch;
                    end else begin
                        trap_addr_d = next_pc;
                        pc_d        = TRAP_PC;
                        state_d     = StTrap;
                    end
                end
            end
            StTrap:  state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            trap_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    // Decoded straight from the state register so an async reset drops imemReq at once.
    assign imemReq    = (state_q == StFetch);
    assign instrValid = (state_q == StExec);
    assign trap       = (state_q == StTrap);
    assign pc         = pc_q;
    assign trapAddr   = trap_addr_q;

endmodule

// File: tb/tb_pc_sequenciador.sv
// Bench for pc_sequenciador: directed scenarios with literal expectations plus randomized
// stimulus, all checked every cycle against a behavioural model of the sequencer.
module tb_pc_sequenciador;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRP_PC = 32'h0000_0080;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Addresult = 32'h0;
    logic [25:0] jumpIndex = 26'h0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic        stall = 1'b0;
    logic        imemAck = 1'b0;
    logic        imemReq;
    logic [31:0] pc;
    logic [31:0] pcincrementado;
    logic        instrValid;
    logic        trap;
    logic [31:0] trapAddr;

    int total = 0;
    int bad = 0;

    pc_sequenciador dut (
        .clock          (clock),
        .reset          (reset),
        .Addresult      (Addresult),
        .jumpIndex      (jumpIndex),
        .branch         (branch),
        .zero           (zero),
        .jump           (jump),
        .stall          (stall),
        .imemAck        (imemAck),
        .imemReq        (imemReq),
        .pc             (pc),
        .pcincrementado (pcincrementado),
        .instrValid     (instrValid),
        .trap           (trap),
        .trapAddr       (trapAddr)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 fetching, 2 executing, 3 trapping.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_trap_addr;
    logic [31:0] m_tgt;

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic jmp,
                                               input logic br, input logic z,
                                               input logic [25:0] ji, input logic [31:0] ar);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (jmp) return (seq & 32'hF000_0000) + ({6'b0, ji} * 32'd4);
        if (br && z) return ar;
        return seq;
    endfunction

    assign m_tgt = model_next(m_pc, jump, branch, zero, jumpIndex, Addresult);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase     <= 0;
            m_pc        <= RST_PC;
            m_trap_addr <= 32'h0;
        end else if (m_phase == 0) begin
            m_phase <= 1;
        end else if (m_phase == 1) begin
            if (imemAck) m_phase <= 2;
        end else if (m_phase == 2) begin
            if (!stall) begin
                if (m_tgt % 4 == 0) begin
                    m_pc    <= m_tgt;
                    m_phase <= 1;
                end else begin
                    m_trap_addr <= m_tgt;
                    m_pc        <= TRP_PC;
                    m_phase     <= 3;
                end
            end
        end else begin
            m_phase <= 1;
        end
    end

    always @(posedge clock) begin
        #3;
        check("m_imemReq", {31'b0, imemReq}, {31'b0, m_phase == 1});
        check("m_instrValid", {31'b0, instrValid}, {31'b0, m_phase == 2});
        check("m_trap", {31'b0, trap}, {31'b0, m_phase == 3});
        check("m_pc", pc, m_pc);
        check("m_pcinc", pcincrementado, m_pc + 32'd4);
        check("m_trapAddr", trapAddr, m_trap_addr);
    end

    task automatic set_ctrl(input logic j, input logic b, input logic z,
                            input logic [31:0] ar, input logic [25:0] ji);
        jump = j;
        branch = b;
        zero = z;
        Addresult = ar;
        jumpIndex = ji;
    endtask

    // Advances at least one cycle, then waits (bounded) for the next fetch cycle.
    task automatic expect_fetch(input logic [31:0] addr, output int n);
        n = 1;
        @(negedge clock);
        while (imemReq !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("fetch_req", {31'b0, imemReq}, 32'd1);
        check("fetch_pc", pc, addr);
    endtask

    initial begin
        int n;
        logic [31:0] r;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_pc", pc, 32'h0);
        check("rst_pcinc", pcincrementado, 32'h4);
        check("rst_req", {31'b0, imemReq}, 32'd0);
        check("rst_trap", {31'b0, trap}, 32'd0);
        check("rst_trapAddr", trapAddr, 32'h0);
        imemAck = 1'b1;
        reset = 1'b1;
        #1 check("idle_req", {31'b0, imemReq}, 32'd0);
        @(negedge clock);
        check("first_req", {31'b0, imemReq}, 32'd1);
        check("first_pc", pc, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            expect_fetch(i * 4, n);
            check("seq_period", n, 2);
            check("seq_fetch_iv", {31'b0, instrValid}, 32'd0);
        end

        // Ack delayed by two cycles on the fetch of pc=4.
        @(negedge clock) reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst2_pc", pc, 32'h0);
        expect_fetch(32'h4, n);
        imemAck = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("ackwait_req", {31'b0, imemReq}, 32'd1);
            check("ackwait_pc", pc, 32'h4);
        end
        imemAck = 1'b1;
        @(negedge clock);
        check("ackdone_iv", {31'b0, instrValid}, 32'd1);
        check("ackdone_pc", pc, 32'h4);

        expect_fetch(32'h8, n);
        set_ctrl(1'b0, 1'b1, 1'b0, 32'h40, 26'h0);
        expect_fetch(32'hC, n);
        set_ctrl(1'b1, 1'b0, 1'b0, 32'h0, 26'h2);
        expect_fetch(32'h8, n);
        set_ctrl(1'b0, 1'b1, 1'b1, 32'h40, 26'h0);
        expect_fetch(32'h40, n);
        set_ctrl(1'b1, 1'b1, 1'b1, 32'h42, 26'h10);
        expect_fetch(32'h40, n);
        check("jump_n", n, 2);
        check("jump_trapAddr", trapAddr, 32'h0);
        set_ctrl(1'b0, 1'b1, 1'b0, 32'h42, 26'h0);
        expect_fetch(32'h44, n);
        check("nz_trapAddr", trapAddr, 32'h0);

        // Misaligned taken branch.
        set_ctrl(1'b0, 1'b1, 1'b1, 32'h42, 26'h0);
        n = 0;
        @(negedge clock);
        while (trap !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("trap_pulse", {31'b0, trap}, 32'd1);
        check("trap_addr", trapAddr, 32'h42);
        check("trap_pc", pc, 32'h80);
        check("trap_req", {31'b0, imemReq}, 32'd0);
        set_ctrl(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        stall = 1'b1;
        @(negedge clock);
        check("posttrap_trap", {31'b0, trap}, 32'd0);
        check("posttrap_req", {31'b0, imemReq}, 32'd1);
        check("posttrap_pc", pc, 32'h80);
        check("posttrap_addr", trapAddr, 32'h42);

        // Three stalled EXEC cycles, then a branch to the top of the address space.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_iv", {31'b0, instrValid}, 32'd1);
            check("stall_req", {31'b0, imemReq}, 32'd0);
            check("stall_pc", pc, 32'h80);
        end
        stall = 1'b0;
        set_ctrl(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 26'h0);
        expect_fetch(32'hFFFF_FFFC, n);
        check("wrap_pcinc", pcincrementado, 32'h0);
        set_ctrl(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        expect_fetch(32'h0, n);
        check("wrap_keep_addr", trapAddr, 32'h42);

        // Reset in the middle of a stalled fetch.
        expect_fetch(32'h4, n);
        imemAck = 1'b0;
        @(negedge clock);
        check("mid_req_before", {31'b0, imemReq}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_req_drop", {31'b0, imemReq}, 32'd0);
        check("mid_pc", pc, RST_PC);
        check("mid_trapAddr", trapAddr, 32'h0);
        @(negedge clock);
        imemAck = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1 check("late_ack_idle_req", {31'b0, imemReq}, 32'd0);
        @(negedge clock);
        check("late_ack_req", {31'b0, imemReq}, 32'd1);
        check("late_ack_iv", {31'b0, instrValid}, 32'd0);
        check("late_ack_pc", pc, 32'h0);

        // Randomized traffic; the model compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r = r & 32'hFFFF_FFFC;
            set_ctrl($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 1, r, 26'($urandom));
            imemAck = $urandom_range(0, 3) != 0;
            stall = $urandom_range(0, 3) == 0;
            reset = $urandom_range(0, 299) != 0;
        end
        @(negedge clock) reset = 1'b1;
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequenciador.md
# pc_sequenciador

Program-counter sequencer for the single-cycle MIPS datapath, i.e. the consumer of the branch-target adder result. It holds the PC and drives `pcincrementado` (PC+4) into the branch adder. It fetches from instruction memory over a req/ack handshake and selects the next PC among sequential, taken-branch and jump targets. A misaligned branch target raises a one-cycle trap and redirects fetch to a fixed trap vector.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `TRAP_PC`, default 32'h0000_0080: PC loaded when a misaligned branch target is detected.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Addresult`  in  32  branch target from the branch adder.
- `jumpIndex`  in  26  instr[25:0] of the current instruction.
- `branch`  in  1  current instruction is a conditional branch.
- `zero`  in  1  ALU zero flag; the branch is taken when `branch & zero`.
- `jump`  in  1  current instruction is j.
- `stall`  in  1  hold the current instruction in EXEC.
- `imemAck`  in  1  instruction memory accepted the fetch at `pc`.
- `imemReq`  out  1  fetch request for address `pc`.
- `pc`  out  32  current PC (registered).
- `pcincrementado`  out  32  `pc + 4`, combinational, mod 2^32.
- `instrValid`  out  1  the fetched instruction is in EXEC; control inputs are sampled.
- `trap`  out  1  one-cycle pulse: misaligned branch target.
- `trapAddr`  out  32  offending target captured on trap.

## Operation
- States: IDLE, FETCH, EXEC, TRAP.
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE; `pc`=RESET_PC.
  - `imemReq`, `instrValid` and `trap` are 0; `trapAddr`=0.
  - A reset asserted mid-fetch drops `imemReq` immediately.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - `imemReq`=1 and `pc` is held stable until `imemAck`=1.
  - On ack, move to EXEC. `imemAck` is ignored in every other state.
- EXEC:
  - `instrValid`=1 and `imemReq`=0.
  - If `stall`=1, remain in EXEC with `pc` and `instrValid` held, and do not sample the controls.
  - Otherwise compute `next` by priority:
    1. `jump`=1: {pcincrementado[31:28], jumpIndex, 2'b00}.
    2. `branch & zero`: `Addresult`.
    3. Otherwise: `pcincrementado`.
  - If `next[1:0]` == 0: `pc` <= `next`, state goes to FETCH.
  - Otherwise: `trapAddr` <= `next`, `pc` <= TRAP_PC, state goes to TRAP.
  - A jump target is always aligned; only a taken branch can trap.
  - A branch with `zero`=0 never traps, whatever `Addresult` holds.
- TRAP:
  - `trap`=1 for exactly one cycle, `imemReq`=0, `instrValid`=0; then FETCH.
  - `trapAddr` holds its value until the next trap or reset.
- Arithmetic: all adds are 32-bit and wrap. PC 32'hFFFF_FFFC gives `pcincrementado`=0.
- Simultaneous `jump` and `branch & zero`: the jump wins, with no trap check on `Addresult`.

## Timing
- Minimum of 2 cycles per instruction: FETCH with a same-cycle ack, then EXEC.
- Each cycle of ack delay adds one FETCH cycle. Each `stall` cycle adds one EXEC cycle.
- `pc` changes only on the clock edge leaving EXEC or TRAP (or on reset); it is stable throughout FETCH and EXEC.
- `instrValid`, `imemReq` and `trap` are decoded from the registered state and are glitch-free.
- `pcincrementado` follows `pc` combinationally, in the same cycle.
- Trap path: EXEC, then TRAP (1 cycle), then FETCH at TRAP_PC. That is 1 extra cycle versus a normal redirect.

## Test plan
- Reset: hold `reset`=0 for 3 cycles. Required: `pc`=0, `pcincrementado`=4, `imemReq`=0, `trap`=0, `trapAddr`=0. After release: 1 IDLE cycle, then `imemReq`=1 at `pc`=0.
- Sequential fetch: ack tied to 1, all controls 0. Required: `pc` takes 0, 4, 8, 12, and `instrValid` pulses every second cycle. With ack delayed by 2 cycles, the FETCH of `pc`=4 lasts 3 cycles with `pc` held.
- Branch at `pc`=8 with `Addresult`=32'h40:
  - `zero`=1: next fetch at 32'h40.
  - Repeat with `zero`=0: next fetch at 32'hC.
  - Jump at `pc`=32'h40 with `jumpIndex`=26'h10 and `branch`=`zero`=1, `Addresult`=32'h42: next fetch at 32'h40, no trap.
- Misaligned target: taken branch with `Addresult`=32'h42. Required:
  - `trap`=1 for one cycle and `trapAddr`=32'h42.
  - Then FETCH at `pc`=32'h80.
  - `trapAddr` keeps 32'h42 afterwards.
- Stall and wrap:
  - `stall`=1 for 3 EXEC cycles: `pc` and `instrValid` held, `imemReq`=0.
  - With `pc`=32'hFFFF_FFFC, sequential advance gives `pcincrementado`=0 and next `pc`=0.
- Reset mid-fetch: assert `reset` while `imemReq`=1 and `imemAck`=0. Required:
  - `imemReq` falls immediately, without waiting for a clock edge, and `pc` becomes RESET_PC.
  - A late `imemAck` during IDLE is ignored.
